// File: rtl/reg_fifo_pkg.sv
// ----------------------------------------------------------------------------
// reg_fifo_pkg
//   Shared helpers for the register FIFO slice:
//     clog2        - ceiling log2 used to size pointers and the occupancy count
//     is_pow2      - power-of-two test for DEPTH
//     params_ok    - WIDTH/DEPTH legality test used by every module of the slice
//     ptr_width    - pointer width for a given DEPTH
//     count_width  - occupancy width for a given DEPTH (must represent DEPTH)
// ----------------------------------------------------------------------------
package reg_fifo_pkg;

  // Ceiling log2. A bounded loop keeps this usable as a constant function.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // WIDTH has no usable default, so a missing override fails here.
  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 2) && is_pow2(depth);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

  // One extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage : reg_fifo_pkg

// File: rtl/reg_fifo_if.sv
// ----------------------------------------------------------------------------
// reg_fifo_if
//   Write/read handshake bundle of the register FIFO.
//     in_valid  / in_ready  / in_data   - write side
//     out_valid / out_ready / out_data  - read side (first-word fall-through)
//     count                             - current occupancy, 0..DEPTH
//   Modports:
//     master - the user of the FIFO (drives writes, consumes reads)
//     slave  - the FIFO itself
// ----------------------------------------------------------------------------
interface reg_fifo_if #(
  parameter int WIDTH = -1,
  parameter int DEPTH = 4
);

  localparam int CW = reg_fifo_pkg::count_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface : reg_fifo_if

// File: rtl/reg_fifo_mem.sv
// ----------------------------------------------------------------------------
// reg_fifo_mem
//   DEPTH x WIDTH storage for reg_fifo. One synchronous write port, one
//   asynchronous read port. Contents are deliberately not reset: the control
//   logic never exposes an entry that has not been written since reset.
//   Ports:
//     clk      - clock
//     wr_en    - write enable (already qualified by the handshake)
//     wr_addr  - write address
//     wr_data  - write data
//     rd_addr  - read address
//     rd_data  - combinational read data
// ----------------------------------------------------------------------------
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = -1,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("reg_fifo_mem: WIDTH must be >= 1 and DEPTH a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read gives the FIFO its first-word fall-through behaviour.
  assign rd_data = mem_array[rd_addr];

endmodule : reg_fifo_mem

// File: rtl/reg_fifo.sv
// ----------------------------------------------------------------------------
// reg_fifo
//   Small first-word fall-through FIFO with a valid/ready handshake on both
//   sides. Control (pointers, occupancy, handshake) lives here; storage is the
//   reg_fifo_mem sub-module.
//   Ports:
//     clk     - clock, all state changes on posedge
//     rst_n   - asynchronous active-low reset; empties the FIFO immediately
//     clk_en  - global stall; low freezes every piece of state and drops
//               both in_ready and out_valid
//     bus     - reg_fifo_if.slave: in_valid/in_ready/in_data,
//               out_valid/out_ready/out_data, count
//   Behaviour notes:
//     - No pass-through when full: in_ready depends only on the current count,
//       so a pop in cycle N frees space visible in cycle N+1.
//     - No bypass when empty: a pushed word is visible after the push edge.
//     - out_data is forced to zero while empty so stale storage never leaks.
// ----------------------------------------------------------------------------
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = -1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  reg_fifo_if.slave    bus
);

  if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("reg_fifo: WIDTH must be >= 1 and DEPTH a power of two >= 2");
  end

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rd_data;

  // --------------------------------------------------------------------------
  // Handshake. rst_n gates in_ready so the writer sees "not ready" for the
  // whole time reset is held, not just from the next edge.
  // --------------------------------------------------------------------------
  assign in_ready  = rst_n && clk_en && (count_reg != COUNT_FULL);
  assign out_valid = clk_en && (count_reg != '0);

  // Both qualifiers already contain clk_en, so a stall blocks every update.
  assign push = bus.in_valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic. DEPTH is a power of two, so pointer wrap is the natural
  // AW-bit rollover with no gap.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  reg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // --------------------------------------------------------------------------
  // Outputs. out_data is qualified by occupancy rather than by out_valid so
  // that the oldest word stays observable during a clk_en stall.
  // --------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (count_reg != '0) ? rd_data : '0;
  assign bus.count     = count_reg;

endmodule : reg_fifo

// File: tb/tb_reg_fifo.sv
// ----------------------------------------------------------------------------
// tb_reg_fifo
//   Directed bench for reg_fifo (WIDTH=8, DEPTH=4). The stimulus process
//   queues every word it expects to come out; a monitor pops and compares on
//   each accepted read. Status outputs are checked directly against
//   hand-computed values.
// ----------------------------------------------------------------------------
module tb_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic clk_en;

  reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input bit expect_out);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (expect_out) exp_q.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.out_ready = 1'b1;
    repeat (n) tick();
    bus.out_ready = 1'b0;
  endtask

  // Monitor: a read is accepted at the next posedge when both valid and ready
  // are high at the preceding negedge.
  initial begin
    logic [7:0] exp_word;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%02h required=none", bus.out_data);
        end else begin
          exp_word = exp_q.pop_front();
          $display("pop data=%02h expected=%02h", bus.out_data, exp_word);
          check("pop_data", 32'(bus.out_data), 32'(exp_word));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    clk_en        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset and idle.
    #1;
    check("rst_count",     32'(bus.count),     0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_out_data",  32'(bus.out_data),  0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready_clk_en_low", 32'(bus.in_ready), 0);
    clk_en = 1'b1;
    #1;
    check("idle_in_ready", 32'(bus.in_ready),  1);
    check("idle_count",    32'(bus.count),     0);
    check("idle_out_data", 32'(bus.out_data),  0);

    // Fill to full, overflow attempt, drain.
    push_word(8'h11, 1'b1);
    check("fwft_valid", 32'(bus.out_valid), 1);
    check("fwft_data",  32'(bus.out_data),  32'h11);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    check("full_count",    32'(bus.count),    4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    push_word(8'h55, 1'b0);
    check("overflow_count", 32'(bus.count),    4);
    check("overflow_head",  32'(bus.out_data), 32'h11);
    pop_n(4);
    check("drain_count",     32'(bus.count),     0);
    check("drain_out_valid", 32'(bus.out_valid), 0);
    check("drain_out_data",  32'(bus.out_data),  0);

    // Streaming: push and pop together; occupancy settles at one.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      tick();
      check("stream_count", 32'(bus.count), 1);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    check("stream_end_count", 32'(bus.count), 0);

    // Full with simultaneous write and read: only the pop happens.
    push_word(8'hA1, 1'b1);
    push_word(8'hA2, 1'b1);
    push_word(8'hA3, 1'b1);
    push_word(8'hA4, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB5;
    bus.out_ready = 1'b1;
    #1;
    check("full_rw_in_ready_same_cycle", 32'(bus.in_ready), 0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("full_rw_count",         32'(bus.count),    3);
    check("full_rw_in_ready_next", 32'(bus.in_ready), 1);
    pop_n(3);
    check("full_rw_drain_count", 32'(bus.count), 0);

    // Stall with both handshakes requested.
    push_word(8'hC1, 1'b1);
    push_word(8'hC2, 1'b1);
    clk_en        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count",     32'(bus.count),     2);
      check("stall_out_valid", 32'(bus.out_valid), 0);
      check("stall_in_ready",  32'(bus.in_ready),  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clk_en        = 1'b1;
    pop_n(2);
    check("stall_drain_count", 32'(bus.count), 0);

    // Reset mid-operation, between edges.
    push_word(8'hD1, 1'b1);
    push_word(8'hD2, 1'b1);
    push_word(8'hD3, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_count",     32'(bus.count),     0);
    check("midrst_out_data",  32'(bus.out_data),  0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready",  32'(bus.in_ready),  0);
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(bus.in_ready), 1);
    push_word(8'h99, 1'b1);
    check("postrst_head", 32'(bus.out_data), 32'h99);
    pop_n(1);
    check("postrst_count", 32'(bus.count), 0);

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_fifo

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 Parameter WIDTH, default -1, data width in bits; SHALL be overridden by every instance (elaboration error if < 1).
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and >= 2 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clk_en  input  1  global stall; low freezes all state.
REQ-006 in_valid  input  1  writer presents in_data.
REQ-007 in_ready  output  1  FIFO can accept a write this cycle.
REQ-008 in_data  input  WIDTH  write data.
REQ-009 out_valid  output  1  out_data holds the oldest entry.
REQ-010 out_ready  input  1  reader consumes out_data this cycle.
REQ-011 out_data  output  WIDTH  oldest entry; first-word fall-through.
REQ-012 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 Push SHALL occur at posedge iff in_valid && in_ready; pop iff out_valid && out_ready.
REQ-014 in_ready SHALL equal clk_en && (count < DEPTH); combinational, independent of out_ready (no pass-through when full).
REQ-015 out_valid SHALL equal clk_en && (count != 0); independent of in_valid (no bypass when empty).
REQ-016 out_data SHALL equal storage[rd_ptr] when count != 0, else all zeros.
REQ-017 Latency: a word pushed at edge N SHALL appear on out_data/out_valid after edge N when the FIFO was empty at N.
REQ-018 Push writes storage[wr_ptr]; wr_ptr increments modulo DEPTH.
REQ-019 Pop increments rd_ptr modulo DEPTH; pointers wrap from DEPTH-1 to 0 with no gap.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-021 Simultaneous push and pop when 0 < count < DEPTH SHALL both complete; order preserved.
REQ-022 When full, a pop in cycle N SHALL make in_ready high in cycle N+1, not N.
REQ-023 When clk_en is low, pointers, count and storage SHALL hold; in_ready and out_valid SHALL be low.
REQ-024 Writes with in_ready low and pops with out_valid low SHALL have no effect (no overflow or underflow).
REQ-025 Data order SHALL be strictly FIFO; no entry is lost or duplicated.

Reset
REQ-026 While rst_n is low: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=0, out_data=0, taking effect immediately and independent of clk.
REQ-027 Storage contents SHALL NOT be reset; they are never observable while count=0.
REQ-028 After rst_n deasserts, in_ready SHALL go high at the first cycle in which clk_en is high.
REQ-029 A reset asserted mid-operation SHALL discard all entries; no stale word may appear on out_data after reset.

Structure
REQ-030 The clog2 helper function and the DEPTH/WIDTH legality checks SHALL live in the shared common include, not locally.
REQ-031 Storage SHALL be a separate sub-module reg_fifo_mem: DEPTH x WIDTH array with one write port gated by write enable and address, and one asynchronous read port.
REQ-032 Control (pointers, count, handshake) SHALL stay in reg_fifo; no other sub-modules.

Verification (WIDTH=8, DEPTH=4)
REQ-033 Reset then idle -> count=0, out_valid=0, out_data=0x00; in_ready=1 from the first clk_en-high cycle.
REQ-034 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; a fifth push of 0x55 is ignored; pops then yield 0x11,0x22,0x33,0x44 and count returns to 0.
REQ-035 Continuous push and pop of 10 incrementing words from 0x01 -> outputs 0x01..0x0A in order; pointers wrap twice; count never exceeds 2.
REQ-036 Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop only; count=3 next cycle, in_ready=1 next cycle.
REQ-037 Two entries held, clk_en=0 for 3 cycles with in_valid=out_ready=1 -> count stays 2, out_valid=0, in_ready=0; after clk_en returns high, output order is unchanged.
REQ-038 Three entries held, rst_n pulsed low between edges -> count=0 and out_data=0x00 immediately; the next push 0x99 is the first word popped.
